// File: rtl/usr_pkg.sv
// Shared opcode and state types for the universal shift register.
package usr_pkg;

    typedef enum logic [2:0] {
        OP_HOLD = 3'd0,
        OP_SHR  = 3'd1,
        OP_SHL  = 3'd2,
        OP_LOAD = 3'd3,
        OP_ROR  = 3'd4,
        OP_ROL  = 3'd5,
        OP_ASR  = 3'd6,
        OP_CLR  = 3'd7
    } op_t;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_SHIFTING = 1'b1
    } state_t;

    localparam int OP_W = 3;

    // Opcodes that honour amt and may run over several edges.
    function automatic logic is_shift(input op_t op);
        return (op == OP_SHR) || (op == OP_SHL) || (op == OP_ROR) ||
               (op == OP_ROL) || (op == OP_ASR);
    endfunction

endpackage

// File: rtl/usr_step_unit.sv
// One-step next-value logic for the universal shift register.
module usr_step_unit
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_t              op,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    input  logic             si,
    output logic [WIDTH-1:0] q_next
);

    always_comb begin
        q_next = q;
        case (op)
            OP_HOLD: q_next = q;
            OP_SHR:  q_next = {si, q[WIDTH-1:1]};
            OP_SHL:  q_next = {q[WIDTH-2:0], si};
            OP_LOAD: q_next = d;
            OP_ROR:  q_next = {q[0], q[WIDTH-1:1]};
            OP_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
            OP_ASR:  q_next = {q[WIDTH-1], q[WIDTH-1:1]};
            OP_CLR:  q_next = '0;
            default: q_next = q;
        endcase
    end

endmodule

// File: rtl/usr_shift_register_n.sv
// Parametrised universal shift register with counted multi-edge shifts and
// a ready/busy/done handshake.
module usr_shift_register_n
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [OP_W-1:0]  op,
    input  logic [CW-1:0]    amt,
    input  logic [WIDTH-1:0] d,
    input  logic             si,
    output logic             op_ready,
    output logic [WIDTH-1:0] q,
    output logic             so_r,
    output logic             so_l,
    output logic             busy,
    output logic             done
);

    state_t           state, state_nx;
    logic [CW-1:0]    rem, rem_nx;
    op_t              lat_op, lat_op_nx;
    op_t              op_in, step_op;
    logic [WIDTH-1:0] q_nx;
    logic             done_nx;
    logic             accept;

    assign op_in    = op_t'(op);
    assign busy     = (state == ST_SHIFTING);
    assign op_ready = !busy;
    assign accept   = op_valid && op_ready;
    assign so_r     = q[0];
    assign so_l     = q[WIDTH-1];

    usr_step_unit #(.WIDTH(WIDTH)) u_step (
        .op     (step_op),
        .q      (q),
        .d      (d),
        .si     (si),
        .q_next (q_nx)
    );

    always_comb begin
        state_nx  = state;
        rem_nx    = rem;
        lat_op_nx = lat_op;
        done_nx   = 1'b0;
        step_op   = OP_HOLD;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (is_shift(op_in) && (amt != '0)) begin
                        // First step happens on the accept edge itself.
                        step_op   = op_in;
                        lat_op_nx = op_in;
                        rem_nx    = amt - 1'b1;
                        if (amt > CW'(1)) begin
                            state_nx = ST_SHIFTING;
                        end else begin
                            done_nx = 1'b1;
                        end
                    end else begin
                        step_op = is_shift(op_in) ? OP_HOLD : op_in;
                        done_nx = 1'b1;
                    end
                end
            end
            ST_SHIFTING: begin
                step_op = lat_op;
                rem_nx  = rem - 1'b1;
                if (rem == CW'(1)) begin
                    state_nx = ST_IDLE;
                    done_nx  = 1'b1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            rem    <= '0;
            lat_op <= OP_HOLD;
            q      <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_nx;
            rem    <= rem_nx;
            lat_op <= lat_op_nx;
            q      <= q_nx;
            done   <= done_nx;
        end
    end

endmodule
